// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end: synchronizes rx, frames bytes LSB first, and keeps
// a rolling word of the last four good bytes for the debug/bench readers.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [31:0] rx_check,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state, state_next;
  logic [1:0]           sync;
  logic                 rxs;
  logic [CW-1:0]        cnt, cnt_next;
  logic [2:0]           idx, idx_next;
  logic [DATA_BITS-1:0] shifter, shift_next;
  logic                 good_frame, bad_frame;

  assign rxs  = sync[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shifter   <= '0;
      rx_data   <= '0;
      rx_check  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shifter   <= shift_next;
      rx_valid  <= good_frame;
      frame_err <= bad_frame;
      if (good_frame) begin
        rx_data  <= shifter;
        rx_check <= {rx_check[23:0], shifter};
      end
    end
  end

  // Counter is cleared explicitly at every sample point so non-power-of-two
  // bit times still land on the right cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    idx_next   = idx;
    shift_next = shifter;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rxs) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxs, shifter[DATA_BITS-1:1]};
          if (idx == IDX_LAST) state_next = STOP;
          else                 idx_next   = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            good_frame = 1'b1;
            state_next = IDLE;
          end else begin
            bad_frame  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed scenarios plus a random mix
// of frames, framing errors and glitches checked against a frame-level model.
module tb_uart_rx_frontend;

  localparam int C = 16;
  localparam int PULSE_OFS = 2 + C / 2 + 9 * C + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] rx_check;
  logic        frame_err;
  logic        busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          t;
    logic [7:0]  b;
    logic [31:0] chk;
  } exp_t;

  exp_t        vq[$];
  int          eq[$];
  exp_t        got;
  logic [7:0]  m_data;
  logic [31:0] m_check;

  uart_rx_frontend #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_check (rx_check),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // All drivers are entered and left one time unit after a rising edge.
  task automatic holdLine(input logic level, input int n);
    rx = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveFrame(input logic [7:0] b, input logic stop_level);
    holdLine(1'b0, C);
    for (int i = 0; i < 8; i++) holdLine(b[i], C);
    holdLine(stop_level, C);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stop_ok);
    exp_t e;
    int   t_pulse;
    t_pulse = cyc + PULSE_OFS;
    if (stop_ok) begin
      m_check = {m_check[23:0], b};
      m_data  = b;
      e.t   = t_pulse;
      e.b   = b;
      e.chk = m_check;
      vq.push_back(e);
    end else begin
      eq.push_back(t_pulse);
    end
    driveFrame(b, stop_ok);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    m_data  = 8'h00;
    m_check = 32'h0;
  endtask

  task automatic applyStimulus(input int n);
    int kind;
    for (int k = 0; k < n; k++) begin
      holdLine(1'b1, $urandom_range(0, C));
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        sendFrame(8'($urandom_range(0, 255)), 1'b1);
      end else if (kind == 7) begin
        sendFrame(8'($urandom_range(0, 255)), 1'b0);
        holdLine(1'b0, $urandom_range(0, 2 * C));
        holdLine(1'b1, C);
      end else begin
        holdLine(1'b0, $urandom_range(1, C / 2 - 3));
        holdLine(1'b1, C);
        checkOutput("glitch_busy_low", busy, 1'b0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      checkOutput("valid_expected", vq.size() != 0, 1'b1);
      if (vq.size() != 0) begin
        got = vq.pop_front();
        checkOutput("valid_time", cyc, got.t);
        checkOutput("valid_rx_data", rx_data, got.b);
        checkOutput("valid_rx_check", rx_check, got.chk);
        checkOutput("valid_busy", busy, 1'b0);
      end
    end
    if (frame_err) begin
      checkOutput("err_expected", eq.size() != 0, 1'b1);
      if (eq.size() != 0) begin
        checkOutput("err_time", cyc, eq.pop_front());
        checkOutput("err_rx_data", rx_data, m_data);
        checkOutput("err_rx_check", rx_check, m_check);
      end
    end
  end

  initial begin
    int n0;
    rx      = 1'b1;
    m_data  = 8'h00;
    m_check = 32'h0;
    applyReset();
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_check", rx_check, 32'h0);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    holdLine(1'b1, C);

    sendFrame(8'h55, 1'b1);
    holdLine(1'b1, C);
    checkOutput("single_rx_data", rx_data, 8'h55);
    checkOutput("single_rx_check", rx_check, 32'h55);

    sendFrame(8'h12, 1'b1);
    sendFrame(8'h34, 1'b1);
    sendFrame(8'h56, 1'b1);
    sendFrame(8'h78, 1'b1);
    holdLine(1'b1, C);
    checkOutput("b2b_rx_check", rx_check, 32'h12345678);
    checkOutput("b2b_rx_data", rx_data, 8'h78);

    n0 = cyc;
    holdLine(1'b0, 4);
    checkOutput("glitch_busy_high", busy, 1'b1);
    holdLine(1'b1, 8);
    checkOutput("glitch_busy_cleared", busy, 1'b0);
    holdLine(1'b1, 192);
    checkOutput("glitch_duration", cyc - n0, 204);

    applyReset();
    holdLine(1'b1, C);
    sendFrame(8'hA5, 1'b0);
    holdLine(1'b0, C);
    checkOutput("break_busy", busy, 1'b1);
    checkOutput("break_rx_data", rx_data, 8'h00);
    holdLine(1'b0, C);
    holdLine(1'b1, C);
    checkOutput("break_exit_busy", busy, 1'b0);
    sendFrame(8'h3C, 1'b1);
    holdLine(1'b1, C);
    checkOutput("after_break_rx_check", rx_check, 32'h3C);

    fork
      driveFrame(8'hFF, 1'b1);
      begin
        repeat (5 * C + C / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_rx_check", rx_check, 32'h0);
        reset   = 1'b0;
        m_data  = 8'h00;
        m_check = 32'h0;
      end
    join
    holdLine(1'b1, C);
    sendFrame(8'h81, 1'b1);
    holdLine(1'b1, C);
    checkOutput("post_reset_rx_data", rx_data, 8'h81);
    checkOutput("post_reset_rx_check", rx_check, 32'h81);

    applyReset();
    holdLine(1'b1, C);
    sendFrame(8'h00, 1'b1);
    holdLine(1'b1, 2);
    checkOutput("lsb_zero_rx_data", rx_data, 8'h00);
    sendFrame(8'hFF, 1'b1);
    holdLine(1'b1, C);
    checkOutput("lsb_ff_rx_data", rx_data, 8'hFF);
    checkOutput("lsb_ff_rx_check", rx_check, 32'h000000FF);

    applyStimulus(40);
    holdLine(1'b1, 3 * C);
    checkOutput("final_rx_data", rx_data, m_data);
    checkOutput("final_rx_check", rx_check, m_check);
    checkOutput("pending_valid", vq.size(), 0);
    checkOutput("pending_err", eq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
